// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data requester and memory signals of the port arbiter
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_ready;
   logic [DW-1:0] i_rdata;

   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_ready;
   logic [DW-1:0] d_rdata;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   logic          stall_i;
   logic          stall_d;
   logic          busy;

   // arbiter side
   modport slave (
      input  i_req, i_addr,
      output i_ready, i_rdata,
      input  d_req, d_we, d_addr, d_wdata,
      output d_ready, d_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata,
      output stall_i, stall_d, busy
   );

   // pipeline/memory side
   modport master (
      output i_req, i_addr,
      input  i_ready, i_rdata,
      output d_req, d_we, d_addr, d_wdata,
      input  d_ready, d_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata,
      input  stall_i, stall_d, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported synchronous memory between fetch and load/store
module mem_port_arbiter #(
   parameter int MEM_LATENCY = 2,
   parameter int AW          = 32,
   parameter int DW          = 32
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
);

   localparam int CW = $clog2(MEM_LATENCY + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_ACCESS = 1'b1;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   logic [0:0]    state_q, state_d;
   logic          owner_q, owner_d;
   logic          last_grant_q, last_grant_d;
   logic          we_q, we_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          mem_en_q, mem_en_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          i_ready_q, i_ready_d;
   logic          d_ready_q, d_ready_d;
   logic [DW-1:0] i_rdata_q, i_rdata_d;
   logic [DW-1:0] d_rdata_q, d_rdata_d;

   logic grant_d_side;
   logic access_done;

   // on a conflict D wins unless it won last time, so neither side starves
   assign grant_d_side = bus.d_req && (!bus.i_req || (last_grant_q != OWN_D));

   // stores need no read latency and finish after the strobe cycle
   assign access_done = we_q || (cnt_q == '0);

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      we_d         = we_q;
      cnt_d        = cnt_q;
      mem_en_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      i_ready_d    = 1'b0;
      d_ready_d    = 1'b0;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;

      case (state_q)
         S_IDLE: begin
            if (grant_d_side) begin
               state_d      = S_ACCESS;
               owner_d      = OWN_D;
               last_grant_d = OWN_D;
               we_d         = bus.d_we;
               cnt_d        = CNT_INIT;
               mem_en_d     = 1'b1;
               mem_we_d     = bus.d_we;
               mem_addr_d   = bus.d_addr;
               mem_wdata_d  = bus.d_wdata;
            end else if (bus.i_req) begin
               state_d      = S_ACCESS;
               owner_d      = OWN_I;
               last_grant_d = OWN_I;
               we_d         = 1'b0;
               cnt_d        = CNT_INIT;
               mem_en_d     = 1'b1;
               mem_addr_d   = bus.i_addr;
            end
         end

         S_ACCESS: begin
            if (access_done) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               if (owner_q == OWN_D) begin
                  d_ready_d = 1'b1;
                  if (!we_q) begin
                     d_rdata_d = bus.mem_rdata;
                  end
               end else begin
                  i_ready_d = 1'b1;
                  i_rdata_d = bus.mem_rdata;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         owner_q      <= OWN_I;
         last_grant_q <= OWN_I;
         we_q         <= 1'b0;
         cnt_q        <= '0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         i_ready_q    <= 1'b0;
         d_ready_q    <= 1'b0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         we_q         <= we_d;
         cnt_q        <= cnt_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         i_ready_q    <= i_ready_d;
         d_ready_q    <= d_ready_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.i_ready   = i_ready_q;
   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_ready   = d_ready_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.stall_i   = bus.i_req & ~i_ready_q;
   assign bus.stall_d   = bus.d_req & ~d_ready_q;
   assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter at latencies 1, 2 and 4
module tb_mem_port_arbiter;

   logic clk;
   logic rst_n;

   mem_port_arbiter_if #(.AW(32), .DW(32)) bus2 ();
   mem_port_arbiter_if #(.AW(32), .DW(32)) bus1 ();
   mem_port_arbiter_if #(.AW(32), .DW(32)) bus4 ();

   mem_port_arbiter #(.MEM_LATENCY(2), .AW(32), .DW(32)) u_dut2 (.clk(clk), .reset(rst_n), .bus(bus2));
   mem_port_arbiter #(.MEM_LATENCY(1), .AW(32), .DW(32)) u_dut1 (.clk(clk), .reset(rst_n), .bus(bus1));
   mem_port_arbiter #(.MEM_LATENCY(4), .AW(32), .DW(32)) u_dut4 (.clk(clk), .reset(rst_n), .bus(bus4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        i_req;
      logic [31:0] i_addr;
      logic        d_req;
      logic        d_we;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic [31:0] mem_rdata;
      logic        e_mem_en;
      logic        e_mem_we;
      logic [31:0] e_mem_addr;
      logic [31:0] e_mem_wdata;
      logic        e_i_ready;
      logic        e_d_ready;
      logic [31:0] e_i_rdata;
      logic [31:0] e_d_rdata;
      logic        e_stall_i;
      logic        e_stall_d;
      logic        e_busy;
   } vec_t;

   vec_t vq[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input logic rst, input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                      input logic [31:0] da, input logic [31:0] dwd, input logic [31:0] mrd,
                      input logic en, input logic we, input logic [31:0] ma, input logic [31:0] mwd,
                      input logic iry, input logic dry, input logic [31:0] ird, input logic [31:0] drd,
                      input logic si, input logic sd, input logic bsy);
      vec_t v;
      v.rst = rst; v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_we = dw; v.d_addr = da;
      v.d_wdata = dwd; v.mem_rdata = mrd;
      v.e_mem_en = en; v.e_mem_we = we; v.e_mem_addr = ma; v.e_mem_wdata = mwd;
      v.e_i_ready = iry; v.e_d_ready = dry; v.e_i_rdata = ird; v.e_d_rdata = drd;
      v.e_stall_i = si; v.e_stall_d = sd; v.e_busy = bsy;
      vq.push_back(v);
   endtask

   initial begin
      rst_n = 1'b0;
      bus2.i_req = 0; bus2.i_addr = 0; bus2.d_req = 0; bus2.d_we = 0; bus2.d_addr = 0; bus2.d_wdata = 0; bus2.mem_rdata = 0;
      bus1.i_req = 0; bus1.i_addr = 0; bus1.d_req = 0; bus1.d_we = 0; bus1.d_addr = 0; bus1.d_wdata = 0; bus1.mem_rdata = 0;
      bus4.i_req = 0; bus4.i_addr = 0; bus4.d_req = 0; bus4.d_we = 0; bus4.d_addr = 0; bus4.d_wdata = 0; bus4.mem_rdata = 0;

      //  rst ir ia      dr dw da      dwd    mrd            en we addr    wdata  iry dry ird            drd      si sd bsy
      // reset and idle
      add(0, 0, 0,      0, 0, 0,      0,     0,             0, 0, 0,      0,     0, 0, 0,             0,       0, 0, 0);
      add(1, 0, 0,      0, 0, 0,      0,     0,             0, 0, 0,      0,     0, 0, 0,             0,       0, 0, 0);
      // single fetch, latency 2
      add(1, 1, 'h100,  0, 0, 0,      0,     0,             0, 0, 0,      0,     0, 0, 0,             0,       1, 0, 0);
      add(1, 1, 'h100,  0, 0, 0,      0,     0,             1, 0, 'h100,  0,     0, 0, 0,             0,       1, 0, 1);
      add(1, 1, 'h100,  0, 0, 0,      0,     0,             0, 0, 'h100,  0,     0, 0, 0,             0,       1, 0, 1);
      add(1, 1, 'h100,  0, 0, 0,      0,     'hDEADBEEF,    0, 0, 'h100,  0,     0, 0, 0,             0,       1, 0, 1);
      add(1, 0, 'h100,  0, 0, 0,      0,     0,             0, 0, 'h100,  0,     1, 0, 'hDEADBEEF,    0,       0, 0, 0);
      add(1, 0, 0,      0, 0, 0,      0,     0,             0, 0, 'h100,  0,     0, 0, 'hDEADBEEF,    0,       0, 0, 0);
      // conflict: D first, then I because D won last
      add(1, 1, 'h100,  1, 0, 'h200,  0,     0,             0, 0, 'h100,  0,     0, 0, 'hDEADBEEF,    0,       1, 1, 0);
      add(1, 1, 'h100,  1, 0, 'h200,  0,     0,             1, 0, 'h200,  0,     0, 0, 'hDEADBEEF,    0,       1, 1, 1);
      add(1, 1, 'h100,  1, 0, 'h200,  0,     0,             0, 0, 'h200,  0,     0, 0, 'hDEADBEEF,    0,       1, 1, 1);
      add(1, 1, 'h100,  1, 0, 'h200,  0,     'h2222,        0, 0, 'h200,  0,     0, 0, 'hDEADBEEF,    0,       1, 1, 1);
      add(1, 1, 'h100,  1, 0, 'h200,  0,     0,             0, 0, 'h200,  0,     0, 1, 'hDEADBEEF,    'h2222,  1, 0, 0);
      add(1, 1, 'h100,  1, 0, 'h200,  0,     0,             1, 0, 'h100,  0,     0, 0, 'hDEADBEEF,    'h2222,  1, 1, 1);
      add(1, 1, 'h100,  1, 0, 'h200,  0,     0,             0, 0, 'h100,  0,     0, 0, 'hDEADBEEF,    'h2222,  1, 1, 1);
      add(1, 1, 'h100,  1, 0, 'h200,  0,     'h11111111,    0, 0, 'h100,  0,     0, 0, 'hDEADBEEF,    'h2222,  1, 1, 1);
      // I completes, D turns into a store
      add(1, 0, 0,      1, 1, 'h300,  'h55,  0,             0, 0, 'h100,  0,     1, 0, 'h11111111,    'h2222,  0, 1, 0);
      add(1, 0, 0,      1, 1, 'h300,  'h55,  'hFFFFFFFF,    1, 1, 'h300,  'h55,  0, 0, 'h11111111,    'h2222,  0, 1, 1);
      add(1, 0, 0,      0, 0, 0,      0,     0,             0, 0, 'h300,  'h55,  0, 1, 'h11111111,    'h2222,  0, 0, 0);
      add(1, 0, 0,      0, 0, 0,      0,     0,             0, 0, 'h300,  'h55,  0, 0, 'h11111111,    'h2222,  0, 0, 0);
      // reset in cycle 2 of a fetch
      add(1, 1, 'h180,  0, 0, 0,      0,     0,             0, 0, 'h300,  'h55,  0, 0, 'h11111111,    'h2222,  1, 0, 0);
      add(1, 1, 'h180,  0, 0, 0,      0,     0,             1, 0, 'h180,  'h55,  0, 0, 'h11111111,    'h2222,  1, 0, 1);
      add(0, 1, 'h180,  0, 0, 0,      0,     0,             0, 0, 0,      0,     0, 0, 0,             0,       1, 0, 0);
      add(0, 0, 0,      0, 0, 0,      0,     'hBAD0BAD0,    0, 0, 0,      0,     0, 0, 0,             0,       0, 0, 0);
      add(1, 0, 0,      0, 0, 0,      0,     0,             0, 0, 0,      0,     0, 0, 0,             0,       0, 0, 0);
      add(1, 0, 0,      0, 0, 0,      0,     'hBAD0BAD0,    0, 0, 0,      0,     0, 0, 0,             0,       0, 0, 0);
      add(1, 0, 0,      0, 0, 0,      0,     0,             0, 0, 0,      0,     0, 0, 0,             0,       0, 0, 0);
      add(1, 1, 'h1C0,  0, 0, 0,      0,     0,             0, 0, 0,      0,     0, 0, 0,             0,       1, 0, 0);
      add(1, 1, 'h1C0,  0, 0, 0,      0,     0,             1, 0, 'h1C0,  0,     0, 0, 0,             0,       1, 0, 1);
      add(1, 1, 'h1C0,  0, 0, 0,      0,     0,             0, 0, 'h1C0,  0,     0, 0, 0,             0,       1, 0, 1);
      add(1, 1, 'h1C0,  0, 0, 0,      0,     'hCAFEF00D,    0, 0, 'h1C0,  0,     0, 0, 0,             0,       1, 0, 1);
      add(1, 0, 0,      0, 0, 0,      0,     0,             0, 0, 'h1C0,  0,     1, 0, 'hCAFEF00D,    0,       0, 0, 0);

      for (int i = 0; i < vq.size(); i++) begin
         @(posedge clk);
         #1;
         rst_n          = vq[i].rst;
         bus2.i_req     = vq[i].i_req;
         bus2.i_addr    = vq[i].i_addr;
         bus2.d_req     = vq[i].d_req;
         bus2.d_we      = vq[i].d_we;
         bus2.d_addr    = vq[i].d_addr;
         bus2.d_wdata   = vq[i].d_wdata;
         bus2.mem_rdata = vq[i].mem_rdata;
         #3;
         chk($sformatf("v%0d mem_en", i),    32'(bus2.mem_en),  32'(vq[i].e_mem_en));
         chk($sformatf("v%0d mem_we", i),    32'(bus2.mem_we),  32'(vq[i].e_mem_we));
         chk($sformatf("v%0d mem_addr", i),  bus2.mem_addr,     vq[i].e_mem_addr);
         chk($sformatf("v%0d mem_wdata", i), bus2.mem_wdata,    vq[i].e_mem_wdata);
         chk($sformatf("v%0d i_ready", i),   32'(bus2.i_ready), 32'(vq[i].e_i_ready));
         chk($sformatf("v%0d d_ready", i),   32'(bus2.d_ready), 32'(vq[i].e_d_ready));
         chk($sformatf("v%0d i_rdata", i),   bus2.i_rdata,      vq[i].e_i_rdata);
         chk($sformatf("v%0d d_rdata", i),   bus2.d_rdata,      vq[i].e_d_rdata);
         chk($sformatf("v%0d stall_i", i),   32'(bus2.stall_i), 32'(vq[i].e_stall_i));
         chk($sformatf("v%0d stall_d", i),   32'(bus2.stall_d), 32'(vq[i].e_stall_d));
         chk($sformatf("v%0d busy", i),      32'(bus2.busy),    32'(vq[i].e_busy));
      end

      // latency 1: fetch held for three accesses, address changes every cycle
      for (int k = 0; k < 12; k++) begin
         logic e_en, e_rdy;
         logic [31:0] e_addr;
         @(posedge clk);
         #1;
         bus1.i_req     = (k <= 8);
         bus1.i_addr    = 32'h10 + 32'(4 * k);
         bus1.mem_rdata = 32'hA000 + 32'(k);
         #3;
         e_en   = (k == 1) || (k == 4) || (k == 7);
         e_rdy  = (k == 3) || (k == 6) || (k == 9);
         e_addr = (k <= 3) ? 32'h10 : (k <= 6) ? 32'h1C : 32'h28;
         chk($sformatf("L1 c%0d mem_en", k),  32'(bus1.mem_en),  32'(e_en));
         chk($sformatf("L1 c%0d i_ready", k), 32'(bus1.i_ready), 32'(e_rdy));
         chk($sformatf("L1 c%0d stall_i", k), 32'(bus1.stall_i), 32'((k <= 8) && !e_rdy));
         if (k >= 1) chk($sformatf("L1 c%0d mem_addr", k), bus1.mem_addr, e_addr);
         if (e_rdy) chk($sformatf("L1 c%0d i_rdata", k), bus1.i_rdata, 32'hA000 + 32'(k - 1));
      end

      // latency 4: D arrives during an I access and must wait for it
      for (int k = 0; k < 14; k++) begin
         logic e_dreq, e_bsy;
         @(posedge clk);
         #1;
         e_dreq         = (k >= 2) && (k <= 11);
         bus4.i_req     = (k <= 5);
         bus4.i_addr    = 32'h40;
         bus4.d_req     = e_dreq;
         bus4.d_we      = 1'b0;
         bus4.d_addr    = 32'h80;
         bus4.mem_rdata = 32'hB000 + 32'(k);
         #3;
         e_bsy = ((k >= 1) && (k <= 5)) || ((k >= 7) && (k <= 11));
         chk($sformatf("L4 c%0d mem_en", k),  32'(bus4.mem_en),  32'((k == 1) || (k == 7)));
         chk($sformatf("L4 c%0d busy", k),    32'(bus4.busy),    32'(e_bsy));
         chk($sformatf("L4 c%0d stall_d", k), 32'(bus4.stall_d), 32'(e_dreq));
         chk($sformatf("L4 c%0d i_ready", k), 32'(bus4.i_ready), 32'(k == 6));
         chk($sformatf("L4 c%0d d_ready", k), 32'(bus4.d_ready), 32'(k == 12));
         if (k == 7)  chk("L4 d mem_addr", bus4.mem_addr, 32'h80);
         if (k == 6)  chk("L4 i_rdata", bus4.i_rdata, 32'hB005);
         if (k == 12) chk("L4 d_rdata", bus4.d_rdata, 32'hB00B);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
